// File: rtl/stg5wb_commit_pkg.sv
// Shared datapath sizes, opcode map and write-back class decode used by the WB stage.
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif

package stg5wb_commit_pkg;

    localparam int OPC_W = `SIZE_OPC;

    localparam logic [OPC_W-1:0] OPC_NOP     = 6'h00;
    localparam logic [OPC_W-1:0] OPC_R_MOV   = 6'h01;
    localparam logic [OPC_W-1:0] OPC_R_ADD   = 6'h02;
    localparam logic [OPC_W-1:0] OPC_R_SUB   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_R_NOT   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_R_AND   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_R_OR    = 6'h06;
    localparam logic [OPC_W-1:0] OPC_R_XOR   = 6'h07;
    localparam logic [OPC_W-1:0] OPC_R_SHL   = 6'h08;
    localparam logic [OPC_W-1:0] OPC_R_SHR   = 6'h09;
    localparam logic [OPC_W-1:0] OPC_RS_ADDs = 6'h0A;
    localparam logic [OPC_W-1:0] OPC_RS_SUBs = 6'h0B;
    localparam logic [OPC_W-1:0] OPC_RS_SHRs = 6'h0C;
    localparam logic [OPC_W-1:0] OPC_I_MOVi  = 6'h10;
    localparam logic [OPC_W-1:0] OPC_I_ADDi  = 6'h11;
    localparam logic [OPC_W-1:0] OPC_I_SUBi  = 6'h12;
    localparam logic [OPC_W-1:0] OPC_I_ANDi  = 6'h13;
    localparam logic [OPC_W-1:0] OPC_I_ORi   = 6'h14;
    localparam logic [OPC_W-1:0] OPC_I_XORi  = 6'h15;
    localparam logic [OPC_W-1:0] OPC_I_SHLi  = 6'h16;
    localparam logic [OPC_W-1:0] OPC_I_SHRi  = 6'h17;
    localparam logic [OPC_W-1:0] OPC_IS_MOVis = 6'h18;
    localparam logic [OPC_W-1:0] OPC_IS_ADDis = 6'h19;
    localparam logic [OPC_W-1:0] OPC_IS_SUBis = 6'h1A;
    localparam logic [OPC_W-1:0] OPC_IS_SHRis = 6'h1B;
    localparam logic [OPC_W-1:0] OPC_S_SRMOV = 6'h20;
    localparam logic [OPC_W-1:0] OPC_R_CMP   = 6'h21;
    localparam logic [OPC_W-1:0] OPC_M_ST    = 6'h28;
    localparam logic [OPC_W-1:0] OPC_B_JMP   = 6'h30;
    localparam logic [OPC_W-1:0] OPC_B_BEQ   = 6'h31;
    localparam logic [OPC_W-1:0] OPC_HALT    = 6'h3F;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_GP   = 2'd1,
        WB_SR   = 2'd2
    } wb_kind_e;

    // Compares, stores and branches leave the register files untouched.
    function automatic wb_kind_e wb_kind(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_R_MOV, OPC_R_ADD, OPC_R_SUB, OPC_R_NOT, OPC_R_AND, OPC_R_OR,
            OPC_R_XOR, OPC_R_SHL, OPC_R_SHR, OPC_RS_ADDs, OPC_RS_SUBs,
            OPC_RS_SHRs, OPC_I_MOVi, OPC_I_ADDi, OPC_I_SUBi, OPC_I_ANDi,
            OPC_I_ORi, OPC_I_XORi, OPC_I_SHLi, OPC_I_SHRi, OPC_IS_MOVis,
            OPC_IS_ADDis, OPC_IS_SUBis, OPC_IS_SHRis: wb_kind = WB_GP;
            OPC_S_SRMOV:                              wb_kind = WB_SR;
            default:                                  wb_kind = WB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stg5wb_commit_if.sv
// MA->WB bundle, latched WB bundle and register read ports. ow_retired exists only with WB_RETIRE_CNT_EN.
interface stg5wb_commit_if #(
    parameter int DATA_W = `SIZE_DATA,
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int GP_IW  = 4,
    parameter int SR_IW  = 2
);
    localparam int OPC_W = stg5wb_commit_pkg::OPC_W;

    logic              iw_valid;
    logic [ADDR_W-1:0] iw_pc;
    logic [DATA_W-1:0] iw_instr;
    logic [OPC_W-1:0]  iw_opc;
    logic [GP_IW-1:0]  iw_tgt_gp;
    logic [SR_IW-1:0]  iw_tgt_sr;
    logic [DATA_W-1:0] iw_result;
    logic              iw_stall;
    logic              iw_flush;

    logic              ow_valid;
    logic [ADDR_W-1:0] ow_pc;
    logic [DATA_W-1:0] ow_instr;
    logic [OPC_W-1:0]  ow_opc;
    logic [GP_IW-1:0]  ow_tgt_gp;
    logic [SR_IW-1:0]  ow_tgt_sr;
    logic [DATA_W-1:0] ow_result;

    logic [GP_IW-1:0]  iw_rd_gp_a;
    logic [GP_IW-1:0]  iw_rd_gp_b;
    logic [SR_IW-1:0]  iw_rd_sr;
    logic [DATA_W-1:0] ow_gp_a;
    logic [DATA_W-1:0] ow_gp_b;
    logic [DATA_W-1:0] ow_sr;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0]       ow_retired;
`endif

    modport master (
`ifdef WB_RETIRE_CNT_EN
        input  ow_retired,
`endif
        output iw_valid, iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_sr, iw_result,
        output iw_stall, iw_flush, iw_rd_gp_a, iw_rd_gp_b, iw_rd_sr,
        input  ow_valid, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result,
        input  ow_gp_a, ow_gp_b, ow_sr
    );

    modport slave (
`ifdef WB_RETIRE_CNT_EN
        output ow_retired,
`endif
        input  iw_valid, iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_sr, iw_result,
        input  iw_stall, iw_flush, iw_rd_gp_a, iw_rd_gp_b, iw_rd_sr,
        output ow_valid, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result,
        output ow_gp_a, ow_gp_b, ow_sr
    );

endinterface

// File: rtl/stg5wb_commit_regfile_2r1w.sv
// Two-read/one-write register file with write-through bypass; indices at or above DEPTH read 0 and never write.
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IW     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IW-1:0]     raddr_a_i,
    input  logic [IW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam logic [IW:0] DEPTH_L = DEPTH[IW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok_s;

    assign wr_ok_s = we_i && ({1'b0, waddr_i} < DEPTH_L);

    // Storage array, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q[waddr_i] <= mem_q[waddr_i];
        end
    end

    // Read port A with bypass.
    always_comb begin
        rdata_a_o = '0;
        if ({1'b0, raddr_a_i} >= DEPTH_L) begin
            rdata_a_o = '0;
        end else if (wr_ok_s && (raddr_a_i == waddr_i)) begin
            rdata_a_o = wdata_i;
        end else begin
            rdata_a_o = mem_q[raddr_a_i];
        end
    end

    // Read port B with bypass.
    always_comb begin
        rdata_b_o = '0;
        if ({1'b0, raddr_b_i} >= DEPTH_L) begin
            rdata_b_o = '0;
        end else if (wr_ok_s && (raddr_b_i == waddr_i)) begin
            rdata_b_o = wdata_i;
        end else begin
            rdata_b_o = mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/stg5wb_commit.sv
// Write-back stage: latches the MA bundle and commits it one cycle later to the GP or SR file.
// Optional retire counter on bus.ow_retired when WB_RETIRE_CNT_EN is defined.
module stg5wb_commit
    import stg5wb_commit_pkg::*;
#(
    parameter int DATA_W = `SIZE_DATA,
    parameter int ADDR_W = `SIZE_ADDR,
    parameter int NUM_GP = 16,
    parameter int NUM_SR = 4,
    localparam int GP_IW = (NUM_GP > 1) ? $clog2(NUM_GP) : 1,
    localparam int SR_IW = (NUM_SR > 1) ? $clog2(NUM_SR) : 1
) (
    input logic            iw_clk,
    input logic            iw_rst,
    stg5wb_commit_if.slave bus
);

    localparam logic [SR_IW:0] NUM_SR_L = NUM_SR[SR_IW:0];

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [GP_IW-1:0]  tgt_gp_q, tgt_gp_d;
    logic [SR_IW-1:0]  tgt_sr_q, tgt_sr_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] sr_q [NUM_SR];
    logic [DATA_W-1:0] sr_rd_s;
    logic [DATA_W-1:0] gp_a_s;
    logic [DATA_W-1:0] gp_b_s;

    wb_kind_e kind_s;
    logic     commit_s;
    logic     gp_we_s;
    logic     sr_we_s;

    // A commit is due whenever the latch holds a valid instruction and may advance; flush does not cancel it.
    assign kind_s   = wb_kind(opc_q);
    assign commit_s = valid_q & ~bus.iw_stall & ~iw_rst;
    assign gp_we_s  = commit_s && (kind_s == WB_GP);
    assign sr_we_s  = commit_s && (kind_s == WB_SR) && ({1'b0, tgt_sr_q} < NUM_SR_L);

    // Latch next state: capture when not stalled, flush clears only the valid bit.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        tgt_gp_d = tgt_gp_q;
        tgt_sr_d = tgt_sr_q;
        result_d = result_q;
        if (!bus.iw_stall) begin
            pc_d     = bus.iw_pc;
            instr_d  = bus.iw_instr;
            opc_d    = bus.iw_opc;
            tgt_gp_d = bus.iw_tgt_gp;
            tgt_sr_d = bus.iw_tgt_sr;
            result_d = bus.iw_result;
        end else begin
            pc_d     = pc_q;
            result_d = result_q;
        end
        if (bus.iw_flush) begin
            valid_d = 1'b0;
        end else if (!bus.iw_stall) begin
            valid_d = bus.iw_valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Latch registers.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            tgt_gp_q <= '0;
            tgt_sr_q <= '0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            tgt_gp_q <= tgt_gp_d;
            tgt_sr_q <= tgt_sr_d;
            result_q <= result_d;
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_GP),
        .IW     (GP_IW)
    ) u_gp (
        .clk_i     (iw_clk),
        .rst_i     (iw_rst),
        .we_i      (gp_we_s),
        .waddr_i   (tgt_gp_q),
        .wdata_i   (result_q),
        .raddr_a_i (bus.iw_rd_gp_a),
        .raddr_b_i (bus.iw_rd_gp_b),
        .rdata_a_o (gp_a_s),
        .rdata_b_o (gp_b_s)
    );

    // Special registers.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            for (int i = 0; i < NUM_SR; i++) begin
                sr_q[i] <= '0;
            end
        end else if (sr_we_s) begin
            sr_q[tgt_sr_q] <= result_q;
        end else begin
            sr_q[tgt_sr_q] <= sr_q[tgt_sr_q];
        end
    end

    // SR read port with bypass of the committing value.
    always_comb begin
        sr_rd_s = '0;
        if ({1'b0, bus.iw_rd_sr} >= NUM_SR_L) begin
            sr_rd_s = '0;
        end else if (sr_we_s && (bus.iw_rd_sr == tgt_sr_q)) begin
            sr_rd_s = result_q;
        end else begin
            sr_rd_s = sr_q[bus.iw_rd_sr];
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Every instruction leaving the latch retires, whether or not it wrote a register.
    always_comb begin
        if (commit_s) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign bus.ow_retired = retired_q;
`endif

    assign bus.ow_valid  = valid_q;
    assign bus.ow_pc     = pc_q;
    assign bus.ow_instr  = instr_q;
    assign bus.ow_opc    = opc_q;
    assign bus.ow_tgt_gp = tgt_gp_q;
    assign bus.ow_tgt_sr = tgt_sr_q;
    assign bus.ow_result = result_q;
    assign bus.ow_gp_a   = gp_a_s;
    assign bus.ow_gp_b   = gp_b_s;
    assign bus.ow_sr     = sr_rd_s;

endmodule

// File: tb/tb_stg5wb_commit.sv
// Bench for stg5wb_commit: directed scenarios plus randomized traffic against a behavioural model.
module tb_stg5wb_commit;
    import stg5wb_commit_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int NGP = 12;
    localparam int NSR = 3;
    localparam int GIW = 4;
    localparam int SIW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    stg5wb_commit_if #(.DATA_W(DW), .ADDR_W(AW), .GP_IW(GIW), .SR_IW(SIW)) bus ();

    stg5wb_commit #(.DATA_W(DW), .ADDR_W(AW), .NUM_GP(NGP), .NUM_SR(NSR)) dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model: architectural latch contents, register files, retire count.
    logic            m_valid;
    logic [AW-1:0]   m_pc;
    logic [DW-1:0]   m_instr;
    logic [OPC_W-1:0] m_opc;
    logic [GIW-1:0]  m_tgt_gp;
    logic [SIW-1:0]  m_tgt_sr;
    logic [DW-1:0]   m_result;
    logic [DW-1:0]   m_gp [NGP];
    logic [DW-1:0]   m_sr [NSR];
    logic [31:0]     m_ret;

    function automatic bit gp_class(input logic [OPC_W-1:0] o);
        return o inside {OPC_R_MOV, OPC_R_ADD, OPC_R_SUB, OPC_R_NOT, OPC_R_AND, OPC_R_OR,
                         OPC_R_XOR, OPC_R_SHL, OPC_R_SHR, OPC_RS_ADDs, OPC_RS_SUBs, OPC_RS_SHRs,
                         OPC_I_MOVi, OPC_I_ADDi, OPC_I_SUBi, OPC_I_ANDi, OPC_I_ORi, OPC_I_XORi,
                         OPC_I_SHLi, OPC_I_SHRi, OPC_IS_MOVis, OPC_IS_ADDis, OPC_IS_SUBis, OPC_IS_SHRis};
    endfunction

    function automatic bit leaving();
        return !rst && m_valid && !bus.iw_stall;
    endfunction

    function automatic logic [DW-1:0] exp_gp(input logic [GIW-1:0] idx);
        if (int'(idx) >= NGP) return '0;
        if (leaving() && gp_class(m_opc) && m_tgt_gp == idx) return m_result;
        return m_gp[idx];
    endfunction

    function automatic logic [DW-1:0] exp_sr(input logic [SIW-1:0] idx);
        if (int'(idx) >= NSR) return '0;
        if (leaving() && m_opc == OPC_S_SRMOV && m_tgt_sr == idx) return m_result;
        return m_sr[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_pc = '0; m_instr = '0; m_opc = '0;
            m_tgt_gp = '0; m_tgt_sr = '0; m_result = '0; m_ret = 32'd0;
            foreach (m_gp[i]) m_gp[i] = '0;
            foreach (m_sr[i]) m_sr[i] = '0;
        end else begin
            if (m_valid && !bus.iw_stall) begin
                if (gp_class(m_opc)) begin
                    if (int'(m_tgt_gp) < NGP) m_gp[m_tgt_gp] = m_result;
                end else if (m_opc == OPC_S_SRMOV) begin
                    if (int'(m_tgt_sr) < NSR) m_sr[m_tgt_sr] = m_result;
                end
                m_ret = m_ret + 32'd1;
            end
            if (!bus.iw_stall) begin
                m_pc = bus.iw_pc; m_instr = bus.iw_instr; m_opc = bus.iw_opc;
                m_tgt_gp = bus.iw_tgt_gp; m_tgt_sr = bus.iw_tgt_sr; m_result = bus.iw_result;
            end
            m_valid = bus.iw_flush ? 1'b0 : (bus.iw_stall ? m_valid : bus.iw_valid);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ow_valid", bus.ow_valid, m_valid);
            if (m_valid) begin
                chk("ow_pc", bus.ow_pc, m_pc);
                chk("ow_instr", bus.ow_instr, m_instr);
                chk("ow_opc", bus.ow_opc, m_opc);
                chk("ow_tgt_gp", bus.ow_tgt_gp, m_tgt_gp);
                chk("ow_tgt_sr", bus.ow_tgt_sr, m_tgt_sr);
                chk("ow_result", bus.ow_result, m_result);
            end
            chk("ow_gp_a", bus.ow_gp_a, exp_gp(bus.iw_rd_gp_a));
            chk("ow_gp_b", bus.ow_gp_b, exp_gp(bus.iw_rd_gp_b));
            chk("ow_sr", bus.ow_sr, exp_sr(bus.iw_rd_sr));
`ifdef WB_RETIRE_CNT_EN
            chk("ow_retired", bus.ow_retired, m_ret);
`endif
        end
    end

    task automatic drive(input logic v, input logic [OPC_W-1:0] opc, input logic [GIW-1:0] tg,
                         input logic [SIW-1:0] ts, input logic [DW-1:0] res,
                         input logic st, input logic fl);
        bus.iw_valid = v; bus.iw_opc = opc; bus.iw_tgt_gp = tg; bus.iw_tgt_sr = ts;
        bus.iw_result = res; bus.iw_stall = st; bus.iw_flush = fl;
        bus.iw_pc = 16'($urandom); bus.iw_instr = 16'($urandom);
    endtask

    task automatic bubble();
        drive(1'b0, OPC_NOP, 4'd0, 2'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
`ifdef WB_RETIRE_CNT_EN
        logic [31:0] exp_ret;
`endif
        bus.iw_rd_gp_a = '0; bus.iw_rd_gp_b = '0; bus.iw_rd_sr = '0;
        bubble();
        step(); step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Populate registers, then reset two cycles later.
        repeat (20) begin
            drive(1'b1, OPC_I_MOVi, 4'($urandom_range(0, 11)), 2'd0, 16'($urandom) | 16'h0001, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, OPC_S_SRMOV, 4'd0, 2'd1, 16'h3C3C, 1'b0, 1'b0);
        step();
        bubble(); step(); step();
        rst = 1'b1;
        step(); step();
        settle();
        chk("rst_valid", bus.ow_valid, 32'd0);
        chk("rst_pc", bus.ow_pc, 32'd0);
        chk("rst_instr", bus.ow_instr, 32'd0);
        chk("rst_opc", bus.ow_opc, 32'd0);
        chk("rst_tgt_gp", bus.ow_tgt_gp, 32'd0);
        chk("rst_tgt_sr", bus.ow_tgt_sr, 32'd0);
        chk("rst_result", bus.ow_result, 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            bus.iw_rd_gp_a = 4'(i); bus.iw_rd_gp_b = 4'(15 - i); bus.iw_rd_sr = 2'(i);
            settle();
            chk("rst_gp_a", bus.ow_gp_a, 32'd0);
            chk("rst_gp_b", bus.ow_gp_b, 32'd0);
            chk("rst_sr", bus.ow_sr, 32'd0);
        end
        step();
        rst = 1'b0;

        // Commit with bypass in the commit cycle.
        drive(1'b1, OPC_I_MOVi, 4'd3, 2'd0, 16'h00A5, 1'b0, 1'b0);
        bus.iw_rd_gp_a = 4'd3;
        step();
        bubble(); settle();
        chk("commit_valid", bus.ow_valid, 32'd1);
        chk("commit_bypass", bus.ow_gp_a, 32'h00A5);
        step(); settle();
        chk("commit_gp3", bus.ow_gp_a, 32'h00A5);

        // Stall holds the latch and defers the commit.
        step();
        drive(1'b1, OPC_R_ADD, 4'd5, 2'd0, 16'd7, 1'b0, 1'b0);
        bus.iw_rd_gp_a = 4'd5;
        step();
        repeat (3) begin
            drive(1'b1, OPC_I_XORi, 4'($urandom), 2'($urandom), 16'h1234, 1'b1, 1'b0);
            settle();
            chk("stall_result", bus.ow_result, 32'd7);
            chk("stall_tgt", bus.ow_tgt_gp, 32'd5);
            chk("stall_opc", bus.ow_opc, 32'(OPC_R_ADD));
            chk("stall_no_write", bus.ow_gp_a, 32'd0);
            step();
        end
`ifdef WB_RETIRE_CNT_EN
        exp_ret = m_ret + 32'd1;
`endif
        bubble(); settle();
        chk("release_bypass", bus.ow_gp_a, 32'd7);
        step(); settle();
        chk("release_gp5", bus.ow_gp_a, 32'd7);
        chk("release_valid", bus.ow_valid, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("release_retired", bus.ow_retired, exp_ret);
`endif

        // Flush alone, then stall with flush.
        step();
        bus.iw_rd_gp_b = 4'd2;
        drive(1'b1, OPC_R_SUB, 4'd2, 2'd0, 16'h5555, 1'b0, 1'b1);
        step();
        bubble(); settle();
        chk("flush_valid", bus.ow_valid, 32'd0);
        step(); settle();
        chk("flush_gp2", bus.ow_gp_b, 32'd0);
        step();
        bus.iw_rd_gp_b = 4'd4;
        drive(1'b1, OPC_R_XOR, 4'd4, 2'd0, 16'h0009, 1'b0, 1'b0);
        step();
        drive(1'b1, OPC_R_OR, 4'd4, 2'd0, 16'h0033, 1'b1, 1'b1);
        step();
        bubble(); settle();
        chk("stallflush_valid", bus.ow_valid, 32'd0);
        step(); settle();
        chk("stallflush_gp4", bus.ow_gp_b, 32'd0);

        // Flush arriving with a commit already due keeps that commit.
        step();
        bus.iw_rd_gp_b = 4'd8;
        drive(1'b1, OPC_I_ADDi, 4'd8, 2'd0, 16'h0088, 1'b0, 1'b0);
        step();
        drive(1'b1, OPC_I_MOVi, 4'd8, 2'd0, 16'h0099, 1'b0, 1'b1);
        step();
        bubble(); settle();
        chk("flushdue_valid", bus.ow_valid, 32'd0);
        chk("flushdue_gp8", bus.ow_gp_b, 32'h0088);

        // SR write leaves GP untouched.
        step();
        bus.iw_rd_sr = 2'd1; bus.iw_rd_gp_a = 4'd6;
        drive(1'b1, OPC_S_SRMOV, 4'd6, 2'd1, 16'h000F, 1'b0, 1'b0);
        step();
        bubble(); settle();
        chk("sr_bypass", bus.ow_sr, 32'h000F);
        step(); settle();
        chk("sr1", bus.ow_sr, 32'h000F);
        chk("sr_gp6", bus.ow_gp_a, 32'd0);

        // Non-writing opcode.
        step();
        bus.iw_rd_sr = 2'd2; bus.iw_rd_gp_a = 4'd7;
        drive(1'b1, OPC_M_ST, 4'd7, 2'd2, 16'hBEEF, 1'b0, 1'b0);
        step();
        bubble(); step(); settle();
        chk("nowr_gp7", bus.ow_gp_a, 32'd0);
        chk("nowr_sr2", bus.ow_sr, 32'd0);

        // Out-of-range targets neither write nor read back.
        step();
        bus.iw_rd_gp_a = 4'd13; bus.iw_rd_sr = 2'd3;
        drive(1'b1, OPC_I_MOVi, 4'd13, 2'd3, 16'h7777, 1'b0, 1'b0);
        step();
        drive(1'b1, OPC_S_SRMOV, 4'd13, 2'd3, 16'h6666, 1'b0, 1'b0);
        settle();
        chk("oor_gp", bus.ow_gp_a, 32'd0);
        step();
        bubble(); settle();
        chk("oor_sr", bus.ow_sr, 32'd0);
        step();

`ifdef WB_RETIRE_CNT_EN
        // Counter wrap.
        step();
        force dut.retired_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        drive(1'b1, OPC_R_CMP, 4'd0, 2'd0, 16'd0, 1'b0, 1'b0);
        step();
        bubble(); step(); settle();
        chk("retired_wrap", bus.ow_retired, 32'd0);
`endif

        // Randomized traffic.
        step();
        repeat (3000) begin
            bus.iw_valid  = ($urandom_range(0, 9) < 7);
            bus.iw_stall  = ($urandom_range(0, 3) == 0);
            bus.iw_flush  = ($urandom_range(0, 9) == 0);
            bus.iw_opc    = ($urandom_range(0, 3) == 0) ? OPC_S_SRMOV : 6'($urandom);
            bus.iw_tgt_gp = 4'($urandom);
            bus.iw_tgt_sr = 2'($urandom);
            bus.iw_result = 16'($urandom);
            bus.iw_pc     = 16'($urandom);
            bus.iw_instr  = 16'($urandom);
            bus.iw_rd_gp_a = 4'($urandom);
            bus.iw_rd_gp_b = 4'($urandom);
            bus.iw_rd_sr   = 2'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        bubble();
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stg5wb_commit.md
STG5WB_COMMIT -- requirements
Module: stg5wb_commit

Interface
REQ-001 SHALL have parameter DATA_W, default `SIZE_DATA, data and result width.
REQ-002 SHALL have parameter ADDR_W, default `SIZE_ADDR, PC width.
REQ-003 SHALL have parameter NUM_GP, default 16, GP register count; index width GP_IW = clog2(NUM_GP).
REQ-004 SHALL have parameter NUM_SR, default 4, SR register count; index width SR_IW = clog2(NUM_SR).
REQ-005 SHALL have port iw_clk, in, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port iw_rst, in, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports iw_valid in 1, iw_pc in ADDR_W, iw_instr in DATA_W, iw_opc in `SIZE_OPC, iw_tgt_gp in GP_IW, iw_tgt_sr in SR_IW, iw_result in DATA_W: incoming MA-stage bundle.
REQ-008 SHALL have port iw_stall, in, 1, hold the latch and suppress commit.
REQ-009 SHALL have port iw_flush, in, 1, invalidate the latch.
REQ-010 SHALL have ports ow_valid out 1, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result out (matching widths): latched bundle.
REQ-011 SHALL have ports iw_rd_gp_a and iw_rd_gp_b in GP_IW, ow_gp_a and ow_gp_b out DATA_W: GP read ports.
REQ-012 SHALL have ports iw_rd_sr in SR_IW, ow_sr out DATA_W: SR read port.

Function
REQ-013 SHALL capture the input bundle into the latch on each edge when iw_stall=0; ow_valid SHALL take iw_valid & ~iw_flush.
REQ-014 SHALL hold every latch field unchanged while iw_stall=1 and iw_flush=0.
REQ-015 SHALL clear ow_valid on iw_flush=1 regardless of iw_stall; other fields are don't-care.
REQ-016 SHALL commit one cycle after capture: when ow_valid=1 and iw_stall=0, write ow_result to GP[ow_tgt_gp] if ow_opc is in the GP-write class, or to SR[ow_tgt_sr] if ow_opc=OPC_S_SRMOV.
REQ-017 GP-write class SHALL be R_MOV, R_ADD, R_SUB, R_NOT, R_AND, R_OR, R_XOR, R_SHL, R_SHR, RS_ADDs, RS_SUBs, RS_SHRs, I_MOVi, I_ADDi, I_SUBi, I_ANDi, I_ORi, I_XORi, I_SHLi, I_SHRi, IS_MOVis, IS_ADDis, IS_SUBis, IS_SHRis; all other opcodes SHALL commit nothing.
REQ-018 SHALL commit at most one write per cycle, exactly once per valid latched instruction, including while stalled for several cycles.
REQ-019 Read ports SHALL be combinational, with write-through bypass: a read of the index being committed this cycle SHALL return ow_result.
REQ-020 SHALL ignore target indices >= NUM_GP or >= NUM_SR (no write); reads of such indices SHALL return 0.
REQ-021 iw_flush SHALL NOT cancel a commit already due this cycle from the current latch.

Reset
REQ-022 On iw_rst=1 at an edge, all latch fields and ow_valid SHALL be 0, all GP and SR registers SHALL be 0, and no commit SHALL occur; reset SHALL override stall and flush.

Configuration
REQ-023 With WB_RETIRE_CNT_EN defined, SHALL add output ow_retired (32 bits, reset 0), which increments by 1 per committed or valid no-write instruction leaving the latch and wraps 0xFFFFFFFF->0; without the macro, the port and counter SHALL be absent.

Structure
REQ-024 Opcode constants and the GP-write class decode SHALL live in the shared opcode header next to sizes.vh, not in this module.
REQ-025 The GP array SHALL be a sub-module regfile_2r1w (parametrised width and depth, 2 read ports with bypass, 1 write port); SR storage SHALL stay inline.

Verification
REQ-026 Reset: assert iw_rst 2 cycles after random writes -> every ow_* = 0, ow_gp_a/ow_gp_b/ow_sr = 0 for all indices.
REQ-027 Commit: send OPC_I_MOVi, tgt_gp=3, result=0x00A5 -> GP[3]=0x00A5 after the commit edge; ow_gp_a with rd=3 shows 0x00A5 in the commit cycle through bypass.
REQ-028 Stall: latch OPC_R_ADD, tgt=5, result=7, then hold iw_stall for 3 cycles and change the inputs -> ow_* unchanged, GP[5] written once after release, retired count +1.
REQ-029 Flush: iw_valid=1 with iw_flush=1, OPC_R_SUB, tgt=2 -> ow_valid=0 and GP[2] unchanged; stall+flush together -> ow_valid=0.
REQ-030 SR and no-write: OPC_S_SRMOV with tgt_sr=1, result=0x0F -> SR[1]=0x0F with no GP change; a non-writing opcode -> no register change.
REQ-031 Counter wrap (macro on): force ow_retired to 0xFFFFFFFF and retire 1 instruction -> 0; build without the macro -> elaborates with no ow_retired port.
